// File: rtl/spi_controller.sv
// SPI Mode 0 bus master that writes one 16-bit frame {rw, addr, data} per request
// into the register peripheral, with a start/busy/done handshake on the system side.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  // Every SPI pin is a flop, so start can only reach the bus through the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 4'd0;
      shreg   <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      ncs     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {rw, addr, data};
            copi    <= rw;
            ncs     <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (div_wrap) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        SHIFT: begin
          if (!div_wrap) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (sclk) begin
              // Falling edge: present the next bit so it is settled well before the next rise.
              sclk  <= 1'b0;
              shreg <= {shreg[14:0], 1'b0};
              copi  <= shreg[14];
            end else if (bit_cnt == 4'd15) begin
              ncs   <= 1'b1;
              copi  <= 1'b0;
              state <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              sclk    <= 1'b1;
            end
          end
        end

        GAP: begin
          if (div_wrap) begin
            div_cnt <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a CLK_DIV=4 instance for the main sequence
// and a CLK_DIV=1 instance for the fastest-clock case.
module tb_spi_controller;

  localparam int H = 4;
  localparam int T = 10;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data = 8'd0;

  logic busy4, done4, sclk4, copi4, ncs4;
  logic busy1, done1, sclk1, copi1, ncs1;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(H)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rw(rw), .addr(addr), .data(data),
    .busy(busy4), .done(done4), .sclk(sclk4), .copi(copi4), .ncs(ncs4)
  );

  spi_controller #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rw(rw), .addr(addr), .data(data),
    .busy(busy1), .done(done1), .sclk(sclk1), .copi(copi1), .ncs(ncs1)
  );

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_frames[$];
  time         exp_done[$];
  logic [15:0] exp1_frames[$];
  time         exp1_done[$];
  int          gaps[$];
  logic [7:0]  regs [0:127];
  int          frames4 = 0;
  int          stab_err = 0;
  int          per1_err = 0;
  int          nbits4 = 0;
  int          nbits1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_line(input string name, input logic [31:0] act);
    checks++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Bus monitor for the CLK_DIV=4 instance: rebuilds frames, feeds the register model.
  logic        p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1;
  logic [15:0] cap4 = 16'd0;
  logic [15:0] e4;
  time         fall_t = 0, rise_t = 0;

  always @(negedge clk) begin
    if (rst) begin
      nbits4 = 0;
      rise_t = 0;
    end else begin
      if (!p_sclk && sclk4) begin
        cap4 = {cap4[14:0], copi4};
        nbits4++;
      end
      if (p_sclk && sclk4 && copi4 !== p_copi) stab_err++;
      if (p_ncs && !ncs4) begin
        fall_t = $time;
        if (rise_t != 0) gaps.push_back(int'((fall_t - rise_t) / T));
        nbits4 = 0;
      end
      if (!p_ncs && ncs4) begin
        rise_t = $time;
        frames4++;
        check("frame_bits", 32'(nbits4), 32'd16);
        check("ncs_low_cycles", 32'((rise_t - fall_t) / T), 32'(33 * H));
        if (exp_frames.size() == 0) fail_line("unexpected_frame", 32'(cap4));
        else begin
          e4 = exp_frames.pop_front();
          check("frame", 32'(cap4), 32'(e4));
        end
        if (cap4[15]) regs[cap4[14:8]] = cap4[7:0];
      end
      if (done4) begin
        if (exp_done.size() == 0) fail_line("unexpected_done", 32'($time));
        else check("done_time", 32'($time - 5), 32'(exp_done.pop_front()));
      end
    end
    p_sclk = sclk4;
    p_copi = copi4;
    p_ncs  = ncs4;
  end

  // Monitor for the CLK_DIV=1 instance.
  logic        q_sclk = 1'b0, q_ncs = 1'b1;
  logic [15:0] cap1 = 16'd0;
  logic [15:0] e1;
  time         last_rise1 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!q_sclk && sclk1) begin
        if (nbits1 > 0 && ($time - last_rise1) != 2 * T) per1_err++;
        last_rise1 = $time;
        cap1 = {cap1[14:0], copi1};
        nbits1++;
      end
      if (q_ncs && !ncs1) nbits1 = 0;
      if (!q_ncs && ncs1) begin
        check("div1_frame_bits", 32'(nbits1), 32'd16);
        if (exp1_frames.size() == 0) fail_line("div1_unexpected_frame", 32'(cap1));
        else begin
          e1 = exp1_frames.pop_front();
          check("div1_frame", 32'(cap1), 32'(e1));
        end
      end
      if (done1) begin
        if (exp1_done.size() == 0) fail_line("div1_unexpected_done", 32'($time));
        else check("div1_done_time", 32'($time - 5), 32'(exp1_done.pop_front()));
      end
    end
    q_sclk = sclk1;
    q_ncs  = ncs1;
  end

  task automatic wait_idle4();
    int n = 0;
    while (busy4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (busy4) fail_line("idle4_timeout", 32'(n));
  endtask

  task automatic write4(input logic r, input logic [6:0] a, input logic [7:0] d);
    wait_idle4();
    rw = r; addr = a; data = d; start4 = 1'b1;
    @(posedge clk);
    exp_frames.push_back({r, a, d});
    exp_done.push_back($time + 34 * H * T);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic write1(input logic r, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    while (busy1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    rw = r; addr = a; data = d; start1 = 1'b1;
    @(posedge clk);
    exp1_frames.push_back({r, a, d});
    exp1_done.push_back($time + 34 * T);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int n;

    rst = 1'b1; start4 = 1'b1; start1 = 1'b1;
    rw = 1'b1; addr = 7'h04; data = 8'h80;
    repeat (3) begin
      @(negedge clk);
      check("rst_ncs", 32'(ncs4), 32'd1);
      check("rst_sclk", 32'(sclk4), 32'd0);
      check("rst_copi", 32'(copi4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      check("rst_ncs_div1", 32'(ncs1), 32'd1);
    end
    rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
    @(negedge clk);

    // Single write to the duty register: frame 0x8480.
    write4(1'b1, 7'h04, 8'h80);
    wait_idle4();
    repeat (3) @(negedge clk);
    check("duty_reg", 32'(regs[4]), 32'h80);

    // Back-to-back sweep; ncs-high is H cycles of GAP plus the done cycle.
    gaps.delete();
    write4(1'b1, 7'h00, 8'hFF);
    write4(1'b1, 7'h01, 8'h0F);
    write4(1'b1, 7'h02, 8'hAA);
    write4(1'b1, 7'h03, 8'h55);
    write4(1'b1, 7'h04, 8'h40);
    wait_idle4();
    repeat (3) @(negedge clk);
    check("reg0", 32'(regs[0]), 32'hFF);
    check("reg1", 32'(regs[1]), 32'h0F);
    check("reg2", 32'(regs[2]), 32'hAA);
    check("reg3", 32'(regs[3]), 32'h55);
    check("reg4", 32'(regs[4]), 32'h40);
    check("gap_count", 32'(gaps.size()), 32'd5);
    for (int i = 1; i < gaps.size(); i++) check("ncs_gap", 32'(gaps[i]), 32'(H + 1));

    // Start during busy must be dropped.
    f0 = frames4;
    write4(1'b1, 7'h01, 8'h11);
    repeat (50) @(negedge clk);
    addr = 7'h02; data = 8'h99; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("busy_during_collision", 32'(busy4), 32'd1);
    wait_idle4();
    repeat (3) @(negedge clk);
    check("collision_frames", 32'(frames4 - f0), 32'd1);
    check("collision_reg1", 32'(regs[1]), 32'h11);
    check("collision_reg2", 32'(regs[2]), 32'hAA);

    // Reset after 6 sclk rises aborts the frame with no done.
    write4(1'b1, 7'h02, 8'h77);
    n = 0;
    while (nbits4 < 6 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (nbits4 < 6) fail_line("rise_wait_timeout", 32'(nbits4));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_ncs", 32'(ncs4), 32'd1);
    check("abort_sclk", 32'(sclk4), 32'd0);
    check("abort_copi", 32'(copi4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    exp_frames.delete();
    exp_done.delete();
    @(negedge clk);
    check("abort_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write4(1'b1, 7'h03, 8'h3C);
    wait_idle4();
    repeat (3) @(negedge clk);
    check("post_abort_reg3", 32'(regs[3]), 32'h3C);
    check("post_abort_reg2", 32'(regs[2]), 32'hAA);

    // CLK_DIV=1 instance: frame 0x80A5, sclk period 2 cycles.
    write1(1'b1, 7'h00, 8'hA5);
    n = 0;
    while (busy1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("div1_period_errors", 32'(per1_err), 32'd0);

    check("pending_frames", 32'(exp_frames.size()), 32'd0);
    check("pending_done", 32'(exp_done.size()), 32'd0);
    check("pending_frames_div1", 32'(exp1_frames.size()), 32'd0);
    check("pending_done_div1", 32'(exp1_done.size()), 32'd0);
    check("copi_stable_high", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
